instruction_fetch: RTL and testbench

//  Fetch stage feeding the instruction register: owns the 9-bit PC, issues reads to the

---
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: decode-side control, instruction memory port and instruction register feed.
// The master modport belongs to the fetch unit; the slave modport to its environment.
interface instruction_fetch_if #(
  parameter int unsigned PcW   = 9,
  parameter int unsigned InstW = 24
);
  logic             stall;
  logic             redirect;
  logic [PcW-1:0]   redirect_pc;
  logic             imem_en;
  logic [PcW-1:0]   imem_addr;
  logic [InstW-1:0] imem_data;
  logic [InstW-1:0] instruction;
  logic [PcW-1:0]   pc_inc0;
  logic             ir_enable;
  logic             halted;

  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_en, imem_addr, instruction, pc_inc0, ir_enable, halted
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_en, imem_addr, instruction, pc_inc0, ir_enable, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, synchronous imem reads, one-entry skid buffer, redirect flush.
// Define FETCH_HALT_EN to stop fetching after delivering an entry whose opcode is HaltOpcode.
module instruction_fetch #(
  parameter int unsigned    PcW     = 9,
  parameter int unsigned    InstW   = 24,
  parameter logic [PcW-1:0] ResetPc = '0
`ifdef FETCH_HALT_EN
  , parameter logic [5:0]   HaltOpcode = 6'h3F
`endif
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  logic [PcW-1:0]   pc_q, pc_d;
  logic             req_valid_q, req_valid_d;
  logic [PcW-1:0]   req_pc_q, req_pc_d;
  logic             skid_valid_q, skid_valid_d;
  logic [InstW-1:0] skid_inst_q, skid_inst_d;
  logic [PcW-1:0]   skid_pc_q, skid_pc_d;
  logic             out_valid_q, out_valid_d;
  logic [InstW-1:0] out_inst_q, out_inst_d;
  logic [PcW-1:0]   out_pc_q, out_pc_d;
  logic             halted_q, halted_d;

  logic             issue;
  logic             ir_enable;
  logic             load_out;
  logic             load_valid;
  logic [InstW-1:0] load_inst;
  logic [PcW-1:0]   load_pc;
  logic [PcW-1:0]   resp_pc;

  always_comb begin
    // Never issue into a held output: at most one response can land in the skid.
    issue      = ~rst & ~bus.redirect & ~halted_q & ~skid_valid_q & ~(bus.stall & out_valid_q);
    ir_enable  = out_valid_q & ~bus.stall;
    load_out   = ~out_valid_q | ir_enable;
    resp_pc    = req_pc_q + 1'b1;
    load_valid = skid_valid_q | req_valid_q;
    load_inst  = skid_valid_q ? skid_inst_q : bus.imem_data;
    load_pc    = skid_valid_q ? skid_pc_q : resp_pc;

    pc_d         = issue ? pc_q + 1'b1 : pc_q;
    req_valid_d  = issue;
    req_pc_d     = issue ? pc_q : req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;
    halted_d     = halted_q;

    if (load_out) begin
      out_valid_d  = load_valid;
      skid_valid_d = 1'b0;
      if (load_valid) begin
        out_inst_d = load_inst;
        out_pc_d   = load_pc;
      end
    end else if (req_valid_q) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = bus.imem_data;
      skid_pc_d    = resp_pc;
    end

`ifdef FETCH_HALT_EN
    // Halt entry is still delivered; anything fetched behind it is dropped.
    if (load_out && load_valid && (load_inst[InstW-1 -: 6] == HaltOpcode)) begin
      halted_d     = 1'b1;
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
`else
    halted_d = 1'b0;
`endif

    if (bus.redirect) begin
      pc_d         = bus.redirect_pc;
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
      halted_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= ResetPc;
      req_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
      halted_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.imem_en     = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = out_inst_q;
  assign bus.pc_inc0     = out_pc_q;
  assign bus.ir_enable   = ir_enable;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: ROM[i]=i behind a one-cycle synchronous read port.
// Covers start-up latency, stall/skid, PC wrap, redirect flush, halt (FETCH_HALT_EN), reset.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [23:0] rom [512];

  instruction_fetch_if #(.PcW(9), .InstW(24)) bus ();

  instruction_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_data <= rom[bus.imem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic cyc(input logic r, input logic st, input logic rd, input logic [8:0] rpc);
    @(posedge clk);
    #1;
    rst             = r;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic out(input string tag, input logic en, input logic [23:0] inst,
                     input logic [8:0] pci);
    chk({tag, ".ir_enable"}, {31'd0, bus.ir_enable}, {31'd0, en});
    if (en) begin
      chk({tag, ".instruction"}, {8'd0, bus.instruction}, {8'd0, inst});
      chk({tag, ".pc_inc0"}, {23'd0, bus.pc_inc0}, {23'd0, pci});
    end
  endtask

  task automatic held(input string tag, input logic [23:0] inst, input logic [8:0] pci);
    chk({tag, ".ir_enable"}, {31'd0, bus.ir_enable}, 32'd0);
    chk({tag, ".held_inst"}, {8'd0, bus.instruction}, {8'd0, inst});
    chk({tag, ".held_pc"}, {23'd0, bus.pc_inc0}, {23'd0, pci});
  endtask

  task automatic mem(input string tag, input logic en, input logic [8:0] addr);
    chk({tag, ".imem_en"}, {31'd0, bus.imem_en}, {31'd0, en});
    if (en) chk({tag, ".imem_addr"}, {23'd0, bus.imem_addr}, {23'd0, addr});
  endtask

  task automatic hlt(input string tag, input logic h);
    chk({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, h});
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 24'(i);
`ifdef FETCH_HALT_EN
    rom[5] = 24'hFC0000;
`endif
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    cyc(1, 0, 0, 9'h0);
    held("reset", 24'h0, 9'h0);
    mem("reset", 0, 9'h0);
    chk("reset.imem_addr", {23'd0, bus.imem_addr}, 32'd0);
    hlt("reset", 0);

    // Start-up latency and one-per-cycle throughput.
    cyc(0, 0, 0, 9'h0); mem("c0", 1, 9'h0); out("c0", 0, 24'h0, 9'h0);
    cyc(0, 0, 0, 9'h0); mem("c1", 1, 9'h1); out("c1", 0, 24'h0, 9'h0);
    cyc(0, 0, 0, 9'h0); out("c2", 1, 24'h0, 9'h1);
    cyc(0, 0, 0, 9'h0); out("c3", 1, 24'h1, 9'h2);

    // Three stalled cycles; response for addr 3 goes to the skid.
    cyc(0, 1, 0, 9'h0); held("c4", 24'h2, 9'h3); mem("c4", 0, 9'h0);
    cyc(0, 1, 0, 9'h0); held("c5", 24'h2, 9'h3); mem("c5", 0, 9'h0);
    cyc(0, 1, 0, 9'h0); held("c6", 24'h2, 9'h3); mem("c6", 0, 9'h0);
    cyc(0, 0, 0, 9'h0); out("c7", 1, 24'h2, 9'h3); mem("c7", 0, 9'h0);
    cyc(0, 0, 0, 9'h0); out("c8", 1, 24'h3, 9'h4); mem("c8", 1, 9'h4);
    cyc(0, 0, 0, 9'h0); out("c9", 0, 24'h0, 9'h0); mem("c9", 1, 9'h5);
    cyc(0, 0, 0, 9'h0); out("c10", 1, 24'h4, 9'h5);
    cyc(0, 0, 0, 9'h0); out("c11", 1, 24'h5, 9'h6);

    // Redirect to 0x1FE coinciding with an accepted entry, then PC wrap.
    cyc(0, 0, 1, 9'h1FE); out("c12", 1, 24'h6, 9'h7); mem("c12", 0, 9'h0);
    cyc(0, 0, 0, 9'h0); out("c13", 0, 24'h0, 9'h0); mem("c13", 1, 9'h1FE);
    cyc(0, 0, 0, 9'h0); out("c14", 0, 24'h0, 9'h0); mem("c14", 1, 9'h1FF);
    cyc(0, 0, 0, 9'h0); out("c15", 1, 24'h1FE, 9'h1FF); mem("c15", 1, 9'h0);
    cyc(0, 0, 0, 9'h0); out("c16", 1, 24'h1FF, 9'h0); mem("c16", 1, 9'h1);
    cyc(0, 0, 0, 9'h0); out("c17", 1, 24'h0, 9'h1);

    // Fill the skid, then redirect to 0x40 while still stalled.
    cyc(0, 1, 0, 9'h0); held("c18", 24'h1, 9'h2);
    cyc(0, 1, 1, 9'h40); out("c19", 0, 24'h0, 9'h0); mem("c19", 0, 9'h0);
    cyc(0, 0, 0, 9'h0); out("c20", 0, 24'h0, 9'h0); mem("c20", 1, 9'h40);
    cyc(0, 0, 0, 9'h0); out("c21", 0, 24'h0, 9'h0); mem("c21", 1, 9'h41);
    cyc(0, 0, 0, 9'h0); out("c22", 1, 24'h40, 9'h41);
    cyc(0, 0, 0, 9'h0); out("c23", 1, 24'h41, 9'h42);

    // Restart at 0 and run through address 5.
    cyc(0, 0, 1, 9'h0); out("c24", 1, 24'h42, 9'h43); mem("c24", 0, 9'h0);
    cyc(0, 0, 0, 9'h0); out("c25", 0, 24'h0, 9'h0); mem("c25", 1, 9'h0);
    cyc(0, 0, 0, 9'h0); out("c26", 0, 24'h0, 9'h0); mem("c26", 1, 9'h1);
    cyc(0, 0, 0, 9'h0); out("c27", 1, 24'h0, 9'h1);
    cyc(0, 0, 0, 9'h0); out("c28", 1, 24'h1, 9'h2);
    cyc(0, 0, 0, 9'h0); out("c29", 1, 24'h2, 9'h3);
    cyc(0, 0, 0, 9'h0); out("c30", 1, 24'h3, 9'h4);
    cyc(0, 0, 0, 9'h0); out("c31", 1, 24'h4, 9'h5); mem("c31", 1, 9'h6);
`ifdef FETCH_HALT_EN
    cyc(0, 0, 0, 9'h0); out("c32", 1, 24'hFC0000, 9'h6); mem("c32", 0, 9'h0); hlt("c32", 1);
    cyc(0, 0, 0, 9'h0); out("c33", 0, 24'h0, 9'h0); mem("c33", 0, 9'h0); hlt("c33", 1);
    cyc(0, 0, 0, 9'h0); out("c34", 0, 24'h0, 9'h0); mem("c34", 0, 9'h0); hlt("c34", 1);
    cyc(0, 0, 1, 9'h0); out("c35", 0, 24'h0, 9'h0); mem("c35", 0, 9'h0); hlt("c35", 1);
`else
    cyc(0, 0, 0, 9'h0); out("c32", 1, 24'h5, 9'h6); mem("c32", 1, 9'h7); hlt("c32", 0);
    cyc(0, 0, 0, 9'h0); out("c33", 1, 24'h6, 9'h7); hlt("c33", 0);
    cyc(0, 0, 0, 9'h0); out("c34", 1, 24'h7, 9'h8);
    cyc(0, 0, 1, 9'h0); out("c35", 1, 24'h8, 9'h9); mem("c35", 0, 9'h0);
`endif
    cyc(0, 0, 0, 9'h0); out("c36", 0, 24'h0, 9'h0); mem("c36", 1, 9'h0); hlt("c36", 0);
    cyc(0, 0, 0, 9'h0); mem("c37", 1, 9'h1);

    // Asynchronous reset while stalled with the skid loaded.
    cyc(0, 1, 0, 9'h0); held("c38", 24'h0, 9'h1); mem("c38", 0, 9'h0);
    cyc(1, 1, 0, 9'h0); held("c39", 24'h0, 9'h0); mem("c39", 0, 9'h0); hlt("c39", 0);
    cyc(0, 0, 0, 9'h0); out("c40", 0, 24'h0, 9'h0); mem("c40", 1, 9'h0);
    cyc(0, 0, 0, 9'h0); out("c41", 0, 24'h0, 9'h0); mem("c41", 1, 9'h1);
    cyc(0, 0, 0, 9'h0); out("c42", 1, 24'h0, 9'h1);
    cyc(0, 0, 0, 9'h0); out("c43", 1, 24'h1, 9'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
